// File: rtl/ball_motion_ctrl.sv
`timescale 1ns/1ps
// ball_motion_ctrl
//   Owns the pong ball position. A frame tick is derived from the VGA scan
//   position; the ball is served, moved every FRAMES_PER_MOVE ticks, bounced
//   off the screen walls and the paddle, and reset after a miss.
//
// Ports
//   clk_in    pixel clock
//   i_rst_n   asynchronous active-low reset
//   i_start   serve request (honoured in IDLE only)
//   i_x/i_y   current scan position
//   i_pad_y   paddle top edge, sampled on move steps
//   o_x_bola  ball left edge x
//   o_y_bola  ball top edge y
//   o_state   0 IDLE, 1 SERVE, 2 MOVE, 3 MISS
//   o_hit     one-cycle pulse on a paddle hit
//   o_miss    one-cycle pulse when the ball passes the paddle
//
// Optional feature macro: BALL_SPEEDUP_EN (speed grows by 1 on each paddle hit,
// saturating at 2*STEP, back to STEP on MISS).
module ball_motion_ctrl #(
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned BALL_SIZE       = 8,
    parameter int unsigned STEP            = 4,
    parameter int unsigned FRAMES_PER_MOVE = 2,
    parameter int unsigned SERVE_FRAMES    = 30,
    parameter int unsigned START_X         = 260,
    parameter int unsigned START_Y         = 300,
    parameter int unsigned PAD_X           = 16,
    parameter int unsigned PAD_W           = 8,
    parameter int unsigned PAD_H           = 64
) (
    input  logic       clk_in,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic [8:0] i_pad_y,
    output logic [9:0] o_x_bola,
    output logic [8:0] o_y_bola,
    output logic [1:0] o_state,
    output logic       o_hit,
    output logic       o_miss
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_MOVE  = 2'd2;
    localparam logic [1:0] ST_MISS  = 2'd3;

    localparam int unsigned CNT_MAX = (SERVE_FRAMES > FRAMES_PER_MOVE) ? SERVE_FRAMES
                                                                       : FRAMES_PER_MOVE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] X_PAD   = 11'(PAD_X + PAD_W);
    localparam logic signed [10:0] BALL_S  = 11'(BALL_SIZE);
    localparam logic signed [10:0] PAD_H_S = 11'(PAD_H);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    // Reset asserts asynchronously; release is re-timed to clk_in.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Frame tick: edge-detected so a held end-of-frame position ticks once.
    logic at_end, at_end_q, tick_q;
    assign at_end = (i_x == 10'(SCREEN_W - 1)) && (i_y == 9'(SCREEN_H - 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            at_end_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            at_end_q <= at_end;
            tick_q   <= at_end & ~at_end_q;
        end
    end

    logic [1:0]       state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             dir_x_q, dir_x_d;   // 1 = +x
    logic             dir_y_q, dir_y_d;   // 1 = +y
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d, miss_q, miss_d;
    logic signed [10:0] spd;

`ifdef BALL_SPEEDUP_EN
    localparam logic signed [10:0] SPD_MAX = 11'(2 * STEP);
    logic signed [10:0] spd_q, spd_d;
    assign spd = spd_q;
`else
    assign spd = STEP_S;
`endif

    logic signed [10:0] nx, ny, ny_res, pad_s;
    logic               y_dir_res, overlap;

    always_comb begin
        nx    = $signed({1'b0, x_q}) + (dir_x_q ? spd : -spd);
        ny    = $signed({2'b00, y_q}) + (dir_y_q ? spd : -spd);
        pad_s = $signed({2'b00, i_pad_y});
        y_dir_res = dir_y_q;
        ny_res    = ny;
        if (ny <= 11'sd0) begin
            ny_res    = 11'sd0;
            y_dir_res = 1'b1;
        end else if (ny >= Y_MAX) begin
            ny_res    = Y_MAX;
            y_dir_res = 1'b0;
        end
        // Paddle overlap uses the wall-resolved y.
        overlap = ((ny_res + BALL_S) > pad_s) && (ny_res < (pad_s + PAD_H_S));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef BALL_SPEEDUP_EN
        spd_d   = spd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                x_d = 10'(START_X);
                y_d = 9'(START_Y);
                if (i_start) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick_q) begin
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_MOVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MOVE: begin
                if (tick_q) begin
                    if (cnt_q == CNT_W'(FRAMES_PER_MOVE - 1)) begin
                        cnt_d   = '0;
                        y_d     = ny_res[8:0];
                        dir_y_d = y_dir_res;
                        if (nx >= X_MAX) begin
                            x_d     = X_MAX[9:0];
                            dir_x_d = 1'b0;
                        end else if (nx <= X_PAD) begin
                            if (!dir_x_q && overlap) begin
                                x_d     = X_PAD[9:0];
                                dir_x_d = 1'b1;
                                hit_d   = 1'b1;
`ifdef BALL_SPEEDUP_EN
                                if (spd_q < SPD_MAX) spd_d = spd_q + 11'sd1;
`endif
                            end else begin
                                state_d = ST_MISS;
                                miss_d  = 1'b1;
                                x_d     = 10'(START_X);
                                y_d     = 9'(START_Y);
`ifdef BALL_SPEEDUP_EN
                                spd_d   = STEP_S;
`endif
                            end
                        end else begin
                            x_d = nx[9:0];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // MISS lasts one cycle; a start request here is dropped.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 10'(START_X);
            y_q     <= 9'(START_Y);
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) spd_q <= STEP_S;
        else        spd_q <= spd_d;
    end
`endif

    assign o_x_bola = x_q;
    assign o_y_bola = y_q;
    assign o_state  = state_q;
    assign o_hit    = hit_q;
    assign o_miss   = miss_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
`timescale 1ns/1ps
module tb_ball_motion_ctrl;

    logic       clk_in = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [9:0] i_x;
    logic [8:0] i_y;
    logic [8:0] i_pad_y;
    logic [9:0] o_x_bola;
    logic [8:0] o_y_bola;
    logic [1:0] o_state;
    logic       o_hit;
    logic       o_miss;

    always #5 clk_in = ~clk_in;

    ball_motion_ctrl dut (
        .clk_in   (clk_in),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_x      (i_x),
        .i_y      (i_y),
        .i_pad_y  (i_pad_y),
        .o_x_bola (o_x_bola),
        .o_y_bola (o_y_bola),
        .o_state  (o_state),
        .o_hit    (o_hit),
        .o_miss   (o_miss)
    );

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] st;
        logic       hit;
        logic       miss;
    } out_t;

    typedef struct {
        string name;
        int    n_frames;
        int    hold;
        int    exp_st;
        int    exp_x;
        int    exp_y;
        int    exp_hit;
    } vec_t;

    out_t sb_q[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference of the ball controller.
    int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_spd, m_hit, m_miss;
    bit m_tick, m_atend;

    task automatic model_reset();
        m_state = 0; m_x = 260; m_y = 300; m_dx = 1; m_dy = -1;
        m_cnt = 0; m_spd = 4; m_hit = 0; m_miss = 0;
        m_tick = 0; m_atend = 0;
    endtask

    task automatic model_step(input int pad);
        int nx, ny;
        nx = m_x + m_dx * m_spd;
        ny = m_y + m_dy * m_spd;
        if (ny <= 0) begin ny = 0; m_dy = 1; end
        else if (ny >= 472) begin ny = 472; m_dy = -1; end
        if (nx >= 632) begin
            m_x = 632; m_dx = -1; m_y = ny;
        end else if (nx <= 24) begin
            if (m_dx < 0 && ny + 8 > pad && ny < pad + 64) begin
                m_x = 24; m_dx = 1; m_y = ny; m_hit = 1;
`ifdef BALL_SPEEDUP_EN
                if (m_spd < 8) m_spd++;
`endif
            end else begin
                m_state = 3; m_miss = 1; m_x = 260; m_y = 300; m_spd = 4;
            end
        end else begin
            m_x = nx; m_y = ny;
        end
    endtask

    task automatic model_clock(input int ix, input int iy, input int start, input int pad);
        bit   ate;
        out_t e;
        ate    = (ix == 639 && iy == 479);
        m_hit  = 0;
        m_miss = 0;
        case (m_state)
            0: begin
                m_x = 260; m_y = 300;
                if (start != 0) begin m_state = 1; m_cnt = 0; m_dx = 1; m_dy = -1; end
            end
            1: if (m_tick) begin
                if (m_cnt == 29) begin m_state = 2; m_cnt = 0; end else m_cnt++;
            end
            2: if (m_tick) begin
                if (m_cnt == 1) begin m_cnt = 0; model_step(pad); end else m_cnt++;
            end
            default: m_state = 0;
        endcase
        m_tick  = ate && !m_atend;
        m_atend = ate;
        e.x = 10'(m_x); e.y = 9'(m_y); e.st = 2'(m_state);
        e.hit = 1'(m_hit); e.miss = 1'(m_miss);
        sb_q.push_back(e);
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare predicted outputs.
    task automatic cyc(input int ix, input int iy, input int start, input int pad);
        out_t e;
        i_x = 10'(ix); i_y = 9'(iy); i_start = 1'(start); i_pad_y = 9'(pad);
        model_clock(ix, iy, start, pad);
        @(posedge clk_in);
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (o_x_bola !== e.x || o_y_bola !== e.y || o_state !== e.st ||
                o_hit !== e.hit || o_miss !== e.miss) begin
                errors++;
                $display("FAIL cycle @%0t: got x=%0d y=%0d st=%0d hit=%0d miss=%0d, expected x=%0d y=%0d st=%0d hit=%0d miss=%0d",
                         $time, o_x_bola, o_y_bola, o_state, o_hit, o_miss,
                         e.x, e.y, e.st, e.hit, e.miss);
            end
        end
    endtask

    task automatic frame(input int hold, input int pad);
        repeat (hold) cyc(639, 479, 0, pad);
        cyc(0, 0, 0, pad);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_x"}, int'(o_x_bola), 260);
        check_eq({tag, "_y"}, int'(o_y_bola), 300);
        check_eq({tag, "_st"}, int'(o_state), 0);
        check_eq({tag, "_hit"}, int'(o_hit), 0);
        check_eq({tag, "_miss"}, int'(o_miss), 0);
    endtask

    initial begin
        bit seen;
        int pad;

        // Milestones from the serve trajectory; step k lands on tick 30+2k.
        vecs[0]  = '{"serve_held",   1,   5, 1, 260, 300, 0};
        vecs[1]  = '{"serve_end",    28,  1, 1, 260, 300, 0};
        vecs[2]  = '{"to_move",      1,   1, 2, 260, 300, 0};
        vecs[3]  = '{"move_wait",    1,   1, 2, 260, 300, 0};
        vecs[4]  = '{"step1",        1,   1, 2, 264, 296, 0};
        vecs[5]  = '{"pre_top",      146, 1, 2, 556, 4,   0};
        vecs[6]  = '{"top_clamp",    2,   1, 2, 560, 0,   0};
        vecs[7]  = '{"top_away",     2,   1, 2, 564, 4,   0};
        vecs[8]  = '{"pre_right",    32,  1, 2, 628, 68,  0};
        vecs[9]  = '{"right_clamp",  2,   1, 2, 632, 72,  0};
        vecs[10] = '{"right_away",   2,   1, 2, 628, 76,  0};
        vecs[11] = '{"bottom_clamp", 198, 1, 2, 232, 472, 0};
        vecs[12] = '{"bottom_away",  2,   1, 2, 228, 468, 0};
        vecs[13] = '{"pre_pad",      100, 1, 2, 28,  268, 0};
        vecs[14] = '{"pad_hit",      2,   1, 2, 24,  264, 1};
`ifdef BALL_SPEEDUP_EN
        vecs[15] = '{"post_hit",     2,   1, 2, 29,  259, 0};
`else
        vecs[15] = '{"post_hit",     2,   1, 2, 28,  260, 0};
`endif

        i_rst_n = 1'b0; i_start = 1'b0; i_x = 10'd320; i_y = 9'd200; i_pad_y = 9'd240;
        model_reset();
        #22;
        check_reset_outputs("reset");
        @(negedge clk_in);
        i_rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 240);

        cyc(0, 0, 1, 240);
        check_eq("serve_enter", int'(o_state), 1);

        for (int i = 0; i < 16; i++) begin
            repeat (vecs[i].n_frames) frame(vecs[i].hold, 240);
            check_eq({vecs[i].name, "_st"}, int'(o_state), vecs[i].exp_st);
            check_eq({vecs[i].name, "_x"}, int'(o_x_bola), vecs[i].exp_x);
            check_eq({vecs[i].name, "_y"}, int'(o_y_bola), vecs[i].exp_y);
            check_eq({vecs[i].name, "_hit"}, int'(o_hit), vecs[i].exp_hit);
        end

        // Keep the paddle away from the ball until it is missed.
        seen = 0;
        for (int f = 0; f < 4000 && !seen; f++) begin
            pad = (m_y < 240) ? 400 : 0;
            frame(1, pad);
            if (o_miss) seen = 1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL miss_timeout: got no miss, expected one within 4000 frames");
        end else begin
            check_eq("miss_st", int'(o_state), 3);
            check_eq("miss_pulse", int'(o_miss), 1);
            check_eq("miss_hit", int'(o_hit), 0);
            check_eq("miss_x", int'(o_x_bola), 260);
            check_eq("miss_y", int'(o_y_bola), 300);
            cyc(0, 0, 1, 0);   // start during MISS is dropped
            check_eq("after_miss_st", int'(o_state), 0);
            check_eq("after_miss_pulse", int'(o_miss), 0);
            cyc(0, 0, 0, 0);
            check_eq("idle_hold_st", int'(o_state), 0);
            check_eq("idle_hold_x", int'(o_x_bola), 260);
        end

        // Re-serve; a start during SERVE must not restart the count.
        cyc(0, 0, 1, 240);
        repeat (10) frame(1, 240);
        cyc(0, 0, 1, 240);
        repeat (22) frame(1, 240);
        check_eq("reserve_st", int'(o_state), 2);
        check_eq("reserve_x", int'(o_x_bola), 264);
        check_eq("reserve_y", int'(o_y_bola), 296);

        // Asynchronous reset in the middle of MOVE.
        repeat (3) frame(1, 240);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        i_rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 240);
        check_eq("post_reset_st", int'(o_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
